lc3_alu_cc: RTL and testbench
=============================

Name: lc3_alu_cc

Overview:
- Execute stage directly downstream of the LC-3 register file.
- Consumes sr1out/sr2out and the IR, performs ADD/AND/NOT/PASSA, and produces the ALU result for the data bus gate.
- Holds the architectural condition codes (NZP), the branch-enable (BEN) bit and a 2's-complement overflow flag, all loaded from the bus under control-store signals.

Parameters:
- DATA_W, 16, datapath width; only 16 is supported, the parameter exists for bench checks.
- CC_RST, 3'b010, NZP value after reset (Z set).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- sr1out  input  16  operand A from register file
- sr2out  input  16  operand B from register file
- ir  input  16  current instruction register
- aluk  input  2  ALU op: 00 ADD, 01 AND, 10 NOT A, 11 PASS A
- gate_alu  input  1  controller is driving alu_out onto the bus this cycle
- ld_cc  input  1  load NZP and overflow flag from data_bus
- ld_ben  input  1  load BEN
- data_bus  input  16  resolved processor bus
- alu_out  output  16  combinational ALU result
- nzp  output  3  registered condition codes {N,Z,P}
- ben  output  1  registered branch enable
- ovf  output  1  registered signed-overflow flag of last CC-loading ADD

Behaviour:
- Reset:
  - rst high asynchronously forces nzp=CC_RST, ben=0, ovf=0.
  - State is held while rst is high.
  - Release is synchronous to the next clk edge.
  - alu_out is combinational and is not reset.
- Operand B (SR2MUX):
  - ir[5]=1: B = sign-extended ir[4:0].
  - ir[5]=0: B = sr2out.
- ALU, zero latency:
  - ADD: A+B modulo 2^16, carry discarded.
  - AND: bitwise A&B.
  - NOT: ~A.
  - PASS: A.
  - B is ignored for NOT and PASS.
- Overflow detect (combinational, internal): addv = (A[15]==B[15]) && (sum[15]!=A[15]). Used for ADD only.
- CC update on the clk edge with ld_cc=1:
  - nzp <= 3'b100 if data_bus[15]=1.
  - nzp <= 3'b010 if data_bus==0.
  - nzp <= 3'b001 otherwise.
  - nzp is always exactly one-hot; 000 and multi-hot values are illegal and must never appear.
- Overflow update on the same edge:
  - ovf <= addv if gate_alu=1 and aluk=00.
  - ovf <= 0 for any other ld_cc (e.g. memory loads, LEA, NOT).
  - ovf holds when ld_cc=0.
- BEN update on the clk edge with ld_ben=1:
  - ben <= |(ir[11:9] & nzp), using the registered nzp value before this edge.
  - If ld_cc and ld_ben assert in the same cycle, ben uses the old nzp and nzp takes the new value.
  - ben holds when ld_ben=0.
- No internal state machine beyond these registers. The controller sequences ld_cc/ld_ben; this block never stalls.
- An X/Z data_bus with ld_cc=1 is a protocol violation and is flagged by a bench assertion, not by RTL.
- Reset asserted in the same cycle as ld_cc or ld_ben: reset wins.

Test Plan:
- Reset, then idle 3 cycles -> nzp=010, ben=0, ovf=0; hold rst high across a ld_cc pulse with bus=0x8000 -> nzp stays 010.
- sr1out=0x7FFF, ir[5]=1, ir[4:0]=00001, aluk=00, gate_alu=1, bus=alu_out, ld_cc -> alu_out=0x8000, nzp=100, ovf=1; next ld_cc with gate_alu=0, bus=0x0005 -> nzp=001, ovf=0.
- sr1out=0x00FF, sr2out=0x0F0F, ir[5]=0: AND -> 0x000F; NOT -> 0xFF00; PASS -> 0x00FF; ADD -> 0x100E; imm5=10000 ADD -> 0x00EF.
- Branch: nzp=010, ir[11:9]=010, ld_ben -> ben=1; ir[11:9]=101, ld_ben -> ben=0; ir[11:9]=111 -> ben=1.
- Simultaneous: nzp=001, ld_cc with bus=0x0000 and ld_ben with ir[11:9]=001 in one cycle -> ben=1 (old P), nzp=010 after the edge.
- Mid-operation reset: nzp=100, ben=1, ovf=1, assert rst between clock edges -> all outputs return to 010/0/0 immediately, without waiting for clk.

Source files
------------

// File: rtl/lc3_alu_cc.sv
// LC-3 execute stage: SR2MUX, ALU, and the NZP / BEN / overflow registers.
// alu_out is combinational; flags load from the resolved data bus.
package lc3_alu_cc_pkg;
  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } aluk_e;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;
endpackage

module lc3_alu_cc
  import lc3_alu_cc_pkg::*;
#(
  parameter int         DATA_W = 16,
  parameter logic [2:0] CC_RST = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sr1out,
  input  logic [DATA_W-1:0] sr2out,
  input  logic [15:0]       ir,
  input  logic [1:0]        aluk,
  input  logic              gate_alu,
  input  logic              ld_cc,
  input  logic              ld_ben,
  input  logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] alu_out,
  output logic [2:0]        nzp,
  output logic              ben,
  output logic              ovf
);

  aluk_e             op;
  logic              is_add;
  logic              is_and;
  logic              is_not;
  logic              is_pass;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] sum;
  logic              addv;
  logic [2:0]        nzp_d;
  logic              ovf_d;
  logic              ben_d;
  logic              unused_ir;

  assign op      = aluk_e'(aluk);
  assign is_add  = (op == ALU_ADD);
  assign is_and  = (op == ALU_AND);
  assign is_not  = (op == ALU_NOT);
  assign is_pass = (op == ALU_PASS);

  // imm5 is sign-extended to the full datapath width
  assign b_op = ir[5] ? {{(DATA_W-5){ir[4]}}, ir[4:0]}
                      : sr2out;

  assign sum = sr1out + b_op;

  assign addv = (sr1out[DATA_W-1] == b_op[DATA_W-1])
             && (sum[DATA_W-1] != sr1out[DATA_W-1]);

  always_comb begin
    alu_out = sr1out;
    unique case (1'b1)
      is_add:  alu_out = sum;
      is_and:  alu_out = sr1out & b_op;
      is_not:  alu_out = ~sr1out;
      is_pass: alu_out = sr1out;
      default: alu_out = sr1out;
    endcase
  end

  // sign bit set implies non-zero, so the arms never overlap
  always_comb begin
    nzp_d = CC_P;
    unique case (1'b1)
      data_bus[DATA_W-1]:   nzp_d = CC_N;
      (data_bus == '0):     nzp_d = CC_Z;
      default:              nzp_d = CC_P;
    endcase
  end

  // only an ALU-driven ADD can leave overflow set
  assign ovf_d = gate_alu & is_add & addv;

  assign ben_d = |(ir[11:9] & nzp);

  assign unused_ir = ^{ir[15:12], ir[8:6]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzp <= CC_RST;
      ovf <= 1'b0;
      ben <= 1'b0;
    end else begin
      if (ld_cc) begin
        nzp <= nzp_d;
        ovf <= ovf_d;
      end
      if (ld_ben) begin
        ben <= ben_d;
      end
    end
  end

endmodule

// File: tb/tb_lc3_alu_cc.sv
// Bench for lc3_alu_cc: directed vectors, reference model, per-cycle compare.
// Literal checks pin the model; the compare process tracks every negedge.
module tb_lc3_alu_cc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sr1out;
  logic [15:0] sr2out;
  logic [15:0] ir;
  logic [1:0]  aluk;
  logic        gate_alu;
  logic        ld_cc;
  logic        ld_ben;
  logic [15:0] data_bus;
  logic [15:0] alu_out;
  logic [2:0]  nzp;
  logic        ben;
  logic        ovf;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  logic [2:0] m_nzp;
  logic       m_ben;
  logic       m_ovf;

  lc3_alu_cc #(.DATA_W(16), .CC_RST(3'b010)) dut (
    .clk      (clk),
    .rst      (rst),
    .sr1out   (sr1out),
    .sr2out   (sr2out),
    .ir       (ir),
    .aluk     (aluk),
    .gate_alu (gate_alu),
    .ld_cc    (ld_cc),
    .ld_ben   (ld_ben),
    .data_bus (data_bus),
    .alu_out  (alu_out),
    .nzp      (nzp),
    .ben      (ben),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic int op_b();
    if (ir[5]) return int'($signed(ir[4:0]));
    return int'(sr2out);
  endfunction

  function automatic logic [15:0] model_alu();
    int a = int'(sr1out);
    int b = op_b();
    logic [15:0] bv = 16'(b);
    case (aluk)
      2'd0:    return 16'((a + b) % 65536);
      2'd1:    return sr1out & bv;
      2'd2:    return 16'(65535 - a);
      default: return sr1out;
    endcase
  endfunction

  function automatic logic model_addv();
    int sa = int'($signed(sr1out));
    int sb = ir[5] ? int'($signed(ir[4:0])) : int'($signed(sr2out));
    int s  = sa + sb;
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [2:0] model_cc(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_nzp <= 3'b010;
      m_ben <= 1'b0;
      m_ovf <= 1'b0;
    end else begin
      if (ld_cc) begin
        m_nzp <= model_cc(data_bus);
        m_ovf <= (gate_alu && aluk == 2'd0) ? model_addv() : 1'b0;
      end
      if (ld_ben) m_ben <= |(ir[11:9] & m_nzp);
    end
  end

  always @(posedge clk) begin
    if (ld_cc && !rst)
      assert (!$isunknown(data_bus))
      else $error("protocol violation: unknown data_bus with ld_cc");
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_alu", alu_out, model_alu());
      chk("cmp_nzp", 16'(nzp), 16'(m_nzp));
      chk("cmp_ben", 16'(ben), 16'(m_ben));
      chk("cmp_ovf", 16'(ovf), 16'(m_ovf));
      chk("cmp_onehot", 16'($countones(nzp)), 16'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sr1out = '0; sr2out = '0; ir = '0; aluk = '0;
    gate_alu = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0; data_bus = '0;
    tick(); tick();
    cmp_en = 1'b1;
    chk("rst_nzp", 16'(nzp), 16'h2);
    chk("rst_ben", 16'(ben), 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    ld_cc = 1'b1; data_bus = 16'h8000;
    tick();
    chk("rst_hold_nzp", 16'(nzp), 16'h2);
    ld_cc = 1'b0; data_bus = '0; rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_nzp", 16'(nzp), 16'h2);
    chk("idle_ovf", 16'(ovf), 16'h0);

    sr1out = 16'h7FFF; ir = 16'h0021; aluk = 2'd0; gate_alu = 1'b1;
    #1 chk("add_ovf_alu", alu_out, 16'h8000);
    data_bus = 16'h8000; ld_cc = 1'b1;
    tick();
    chk("add_ovf_nzp", 16'(nzp), 16'h4);
    chk("add_ovf_ovf", 16'(ovf), 16'h1);
    gate_alu = 1'b0; data_bus = 16'h0005;
    tick();
    chk("load_nzp", 16'(nzp), 16'h1);
    chk("load_ovf", 16'(ovf), 16'h0);
    ld_cc = 1'b0;

    sr1out = 16'h00FF; sr2out = 16'h0F0F; ir = 16'h0000;
    aluk = 2'd1; #1 chk("and", alu_out, 16'h000F);
    aluk = 2'd2; #1 chk("not", alu_out, 16'hFF00);
    aluk = 2'd3; #1 chk("pass", alu_out, 16'h00FF);
    aluk = 2'd0; #1 chk("add_reg", alu_out, 16'h100E);
    ir = 16'h0030; #1 chk("add_imm_neg", alu_out, 16'h00EF);

    sr1out = 16'h8000; sr2out = 16'hFFFF; ir = 16'h0000;
    aluk = 2'd0; gate_alu = 1'b1;
    #1 chk("negovf_alu", alu_out, 16'h7FFF);
    data_bus = 16'h7FFF; ld_cc = 1'b1;
    tick();
    chk("negovf_nzp", 16'(nzp), 16'h1);
    chk("negovf_ovf", 16'(ovf), 16'h1);
    tick();
    ld_cc = 1'b0;
    tick();
    chk("ovf_hold", 16'(ovf), 16'h1);

    sr1out = 16'h0000; aluk = 2'd2;
    #1 chk("not_zero", alu_out, 16'hFFFF);
    data_bus = 16'hFFFF; ld_cc = 1'b1;
    tick();
    chk("not_nzp", 16'(nzp), 16'h4);
    chk("not_ovf", 16'(ovf), 16'h0);
    gate_alu = 1'b0;

    data_bus = 16'h0000;
    tick();
    ld_cc = 1'b0;
    ir = 16'h0400; ld_ben = 1'b1;
    tick();
    chk("ben_z", 16'(ben), 16'h1);
    ir = 16'h0A00;
    tick();
    chk("ben_np", 16'(ben), 16'h0);
    ir = 16'h0E00;
    tick();
    chk("ben_nzp", 16'(ben), 16'h1);
    ld_ben = 1'b0;

    ld_cc = 1'b1; data_bus = 16'h0005;
    tick();
    data_bus = 16'h0000; ir = 16'h0200; ld_ben = 1'b1;
    tick();
    chk("sim_ben", 16'(ben), 16'h1);
    chk("sim_nzp", 16'(nzp), 16'h2);
    ld_cc = 1'b0; ld_ben = 1'b0;

    sr1out = 16'h7FFF; ir = 16'h0821; aluk = 2'd0; gate_alu = 1'b1;
    data_bus = 16'h8000; ld_cc = 1'b1;
    tick();
    ld_cc = 1'b0; gate_alu = 1'b0; ld_ben = 1'b1;
    tick();
    ld_ben = 1'b0;
    chk("pre_nzp", 16'(nzp), 16'h4);
    chk("pre_ben", 16'(ben), 16'h1);
    chk("pre_ovf", 16'(ovf), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_nzp", 16'(nzp), 16'h2);
    chk("async_ben", 16'(ben), 16'h0);
    chk("async_ovf", 16'(ovf), 16'h0);
    tick();
    rst = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
